// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: FSM encoding, the empty-tag constant
// and default bus widths.
package cdb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_t;

  // Tag value meaning "no reservation station"; never a valid broadcast source.
  localparam logic [5:0] NO_RS_TAG = 6'b000000;

  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after 'start',
// wrapping modulo N.
module cdb_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0] pos;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter with registered one-cycle broadcast.
// Optional write/tag check enabled by defining CDB_ARB_WRITE_CHECK_EN.
//
// state      | meaning
// IDLE       | no grant; arbitrate among rts each cycle
// GRANT      | xmit held for XMIT_CYCLES cycles; last cycle captures the bus
// RELEASE    | one dead cycle so the winner's rts is low before re-arbitration
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int XMIT_CYCLES = 1,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int DATA_W      = DEF_DATA_W,
  localparam int IW         = $clog2(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] rts,
  output logic [NUM_UNITS-1:0] xmit,
  input  logic [DATA_W-1:0]    CDB_data,
  input  logic [TAG_W-1:0]     CDB_source,
  input  logic                 CDB_write,
  output logic                 cdb_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 bc_valid,
  output logic [TAG_W-1:0]     bc_tag,
  output logic [DATA_W-1:0]    bc_data,
  output logic                 protocol_error
);

  arb_state_t       state;
  logic [IW-1:0]    rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             bus_ok;

  cdb_arbiter_rr_pick #(.N(NUM_UNITS), .IW(IW)) u_pick (
    .req   (rts),
    .start (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

`ifdef CDB_ARB_WRITE_CHECK_EN
  assign bus_ok = CDB_write && (CDB_source != TAG_W'(NO_RS_TAG));
`else
  logic unused_write;
  assign unused_write = CDB_write;
  assign bus_ok       = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      hold_cnt       <= '0;
      xmit           <= '0;
      cdb_busy       <= 1'b0;
      grant_id       <= '0;
      bc_valid       <= 1'b0;
      bc_tag         <= '0;
      bc_data        <= '0;
      protocol_error <= 1'b0;
    end else begin
      bc_valid       <= 1'b0;
      protocol_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            xmit     <= {{(NUM_UNITS-1){1'b0}}, 1'b1} << win_idx;
            cdb_busy <= 1'b1;
            grant_id <= win_idx;
            hold_cnt <= CNT_W'(XMIT_CYCLES - 1);
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (hold_cnt == '0) begin
            bc_tag         <= CDB_source;
            bc_data        <= CDB_data;
            bc_valid       <= bus_ok;
            protocol_error <= !bus_ok;
            xmit           <= '0;
            cdb_busy       <= 1'b0;
            rr_ptr         <= (grant_id == IW'(NUM_UNITS - 1)) ? '0 : grant_id + 1'b1;
            state          <= ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (XMIT_CYCLES=1) plus hand
// sequences on a second instance with XMIT_CYCLES=3.
module tb_cdb_arbiter;

`ifdef CDB_ARB_WRITE_CHECK_EN
  localparam logic WCHK = 1'b1;
`else
  localparam logic WCHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, reset3;
  logic [3:0]  rts, rts3;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_source;
  logic        cdb_write;

  logic [3:0]  xmit, xmit3;
  logic        busy, busy3;
  logic [1:0]  gid, gid3;
  logic        bcv, bcv3;
  logic [5:0]  tag, tag3;
  logic [31:0] bdat, bdat3;
  logic        perr, perr3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(1), .TAG_W(6), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .rts(rts), .xmit(xmit),
    .CDB_data(cdb_data), .CDB_source(cdb_source), .CDB_write(cdb_write),
    .cdb_busy(busy), .grant_id(gid), .bc_valid(bcv), .bc_tag(tag),
    .bc_data(bdat), .protocol_error(perr)
  );

  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(3), .TAG_W(6), .DATA_W(32)) dut3 (
    .clock(clock), .reset(reset3), .rts(rts3), .xmit(xmit3),
    .CDB_data(cdb_data), .CDB_source(cdb_source), .CDB_write(cdb_write),
    .cdb_busy(busy3), .grant_id(gid3), .bc_valid(bcv3), .bc_tag(tag3),
    .bc_data(bdat3), .protocol_error(perr3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rts;
    logic [5:0]  src;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  x;
    logic [1:0]  gid;
    logic        bcv;
    logic [5:0]  tag;
    logic [31:0] bdat;
    logic        perr;
  } vec_t;

  vec_t vecs[36];

  function automatic vec_t mk(logic rst, logic [3:0] r, logic [5:0] s, logic [31:0] d,
                              logic w, logic [3:0] x, logic [1:0] g, logic bv,
                              logic [5:0] t, logic [31:0] bd, logic pe);
    vec_t v;
    v.rst = rst; v.rts = r; v.src = s; v.data = d; v.wr = w;
    v.x = x; v.gid = g; v.bcv = bv; v.tag = t; v.bdat = bd; v.perr = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    chk("onehot0_xmit", {31'd0, $onehot0(xmit)}, 32'd1);
    chk("onehot0_xmit3", {31'd0, $onehot0(xmit3)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_x3 [6];
    logic       exp_b3 [6];

    // rst rts    src  data  wr | xmit  gid bcv   tag  bdat  perr
    vecs[0]  = mk(1, 4'b0000, 0,  0,    1, 4'b0000, 0, 0,     0,  0,    0);
    vecs[1]  = mk(0, 4'b0010, 2,  7,    1, 4'b0010, 1, 0,     0,  0,    0);
    vecs[2]  = mk(0, 4'b0010, 2,  7,    1, 4'b0000, 1, 1,     2,  7,    0);
    vecs[3]  = mk(0, 4'b0000, 2,  7,    1, 4'b0000, 1, 0,     2,  7,    0);
    vecs[4]  = mk(1, 4'b1011, 2,  7,    1, 4'b0000, 0, 0,     0,  0,    0);
    vecs[5]  = mk(0, 4'b1011, 5,  100,  1, 4'b0001, 0, 0,     0,  0,    0);
    vecs[6]  = mk(0, 4'b1011, 5,  100,  1, 4'b0000, 0, 1,     5,  100,  0);
    vecs[7]  = mk(0, 4'b1010, 5,  100,  1, 4'b0000, 0, 0,     5,  100,  0);
    vecs[8]  = mk(0, 4'b1011, 6,  200,  1, 4'b0010, 1, 0,     5,  100,  0);
    vecs[9]  = mk(0, 4'b1011, 6,  200,  1, 4'b0000, 1, 1,     6,  200,  0);
    vecs[10] = mk(0, 4'b1001, 6,  200,  1, 4'b0000, 1, 0,     6,  200,  0);
    vecs[11] = mk(0, 4'b1011, 7,  300,  1, 4'b1000, 3, 0,     6,  200,  0);
    vecs[12] = mk(0, 4'b1011, 7,  300,  1, 4'b0000, 3, 1,     7,  300,  0);
    vecs[13] = mk(0, 4'b0011, 7,  300,  1, 4'b0000, 3, 0,     7,  300,  0);
    vecs[14] = mk(0, 4'b1011, 8,  400,  1, 4'b0001, 0, 0,     7,  300,  0);
    vecs[15] = mk(0, 4'b1011, 8,  400,  1, 4'b0000, 0, 1,     8,  400,  0);
    vecs[16] = mk(0, 4'b1010, 8,  400,  1, 4'b0000, 0, 0,     8,  400,  0);
    vecs[17] = mk(0, 4'b1011, 9,  500,  1, 4'b0010, 1, 0,     8,  400,  0);
    vecs[18] = mk(0, 4'b1011, 9,  500,  1, 4'b0000, 1, 1,     9,  500,  0);
    vecs[19] = mk(0, 4'b1001, 9,  500,  1, 4'b0000, 1, 0,     9,  500,  0);
    vecs[20] = mk(0, 4'b1011, 10, 600,  1, 4'b1000, 3, 0,     9,  500,  0);
    vecs[21] = mk(0, 4'b1011, 10, 600,  1, 4'b0000, 3, 1,     10, 600,  0);
    vecs[22] = mk(0, 4'b0000, 10, 600,  1, 4'b0000, 3, 0,     10, 600,  0);
    vecs[23] = mk(0, 4'b0000, 10, 600,  1, 4'b0000, 3, 0,     10, 600,  0);
    vecs[24] = mk(0, 4'b0100, 11, 700,  0, 4'b0100, 2, 0,     10, 600,  0);
    vecs[25] = mk(0, 4'b0100, 11, 700,  0, 4'b0000, 2, !WCHK, 11, 700,  WCHK);
    vecs[26] = mk(0, 4'b0000, 11, 700,  1, 4'b0000, 2, 0,     11, 700,  0);
    vecs[27] = mk(0, 4'b1001, 12, 800,  1, 4'b1000, 3, 0,     11, 700,  0);
    vecs[28] = mk(0, 4'b1001, 12, 800,  1, 4'b0000, 3, 1,     12, 800,  0);
    vecs[29] = mk(0, 4'b0001, 12, 800,  1, 4'b0000, 3, 0,     12, 800,  0);
    vecs[30] = mk(0, 4'b1001, 0,  900,  1, 4'b0001, 0, 0,     12, 800,  0);
    vecs[31] = mk(0, 4'b1001, 0,  900,  1, 4'b0000, 0, !WCHK, 0,  900,  WCHK);
    vecs[32] = mk(0, 4'b0000, 0,  900,  1, 4'b0000, 0, 0,     0,  900,  0);
    vecs[33] = mk(0, 4'b1000, 13, 1000, 1, 4'b1000, 3, 0,     0,  900,  0);
    vecs[34] = mk(0, 4'b1000, 13, 1000, 1, 4'b0000, 3, 1,     13, 1000, 0);
    vecs[35] = mk(0, 4'b0000, 13, 1000, 1, 4'b0000, 3, 0,     13, 1000, 0);

    reset3 = 1'b1;
    rts3   = 4'b0000;

    for (int i = 0; i < 36; i++) begin
      reset      = vecs[i].rst;
      rts        = vecs[i].rts;
      cdb_source = vecs[i].src;
      cdb_data   = vecs[i].data;
      cdb_write  = vecs[i].wr;
      step();
      chk($sformatf("v%0d_xmit", i), {28'd0, xmit}, {28'd0, vecs[i].x});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, |vecs[i].x});
      chk($sformatf("v%0d_gid", i), {30'd0, gid}, {30'd0, vecs[i].gid});
      chk($sformatf("v%0d_bcv", i), {31'd0, bcv}, {31'd0, vecs[i].bcv});
      chk($sformatf("v%0d_tag", i), {26'd0, tag}, {26'd0, vecs[i].tag});
      chk($sformatf("v%0d_bdat", i), bdat, vecs[i].bdat);
      chk($sformatf("v%0d_perr", i), {31'd0, perr}, {31'd0, vecs[i].perr});
    end

    // Three-cycle hold: unit 2 drops rts mid-grant, unit 0 raises rts during grant.
    reset      = 1'b1;
    rts        = 4'b0000;
    cdb_source = 6'd33;
    cdb_data   = 32'hABCD;
    cdb_write  = 1'b1;
    step();
    chk("h3_reset_xmit", {28'd0, xmit3}, 32'd0);
    chk("h3_reset_gid", {30'd0, gid3}, 32'd0);
    reset3 = 1'b0;
    rts3   = 4'b0100;
    exp_x3 = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
    exp_b3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) rts3 = 4'b0001;
      chk($sformatf("h3_c%0d_xmit", c), {28'd0, xmit3}, {28'd0, exp_x3[c]});
      chk($sformatf("h3_c%0d_bcv", c), {31'd0, bcv3}, {31'd0, exp_b3[c]});
      chk($sformatf("h3_c%0d_busy", c), {31'd0, busy3}, {31'd0, |exp_x3[c]});
    end
    chk("h3_tag", {26'd0, tag3}, 32'd33);
    chk("h3_bdat", bdat3, 32'hABCD);
    chk("h3_gid", {30'd0, gid3}, 32'd0);

    // Reset in the second cycle of a grant to unit 0.
    step();
    chk("rst_mid_pre_xmit", {28'd0, xmit3}, 32'b0001);
    reset3 = 1'b1;
    step();
    chk("rst_mid_xmit", {28'd0, xmit3}, 32'd0);
    chk("rst_mid_bcv", {31'd0, bcv3}, 32'd0);
    chk("rst_mid_tag", {26'd0, tag3}, 32'd0);
    reset3 = 1'b0;
    rts3   = 4'b0000;
    step();
    chk("rst_after_bcv", {31'd0, bcv3}, 32'd0);
    chk("rst_after_xmit", {28'd0, xmit3}, 32'd0);
    // rr_ptr back at 0 means unit 0 wins a full request vector.
    rts3 = 4'b1111;
    step();
    chk("rst_rrptr_xmit", {28'd0, xmit3}, 32'b0001);
    chk("rst_rrptr_gid", {30'd0, gid3}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among functional units: adder RS unit, multiplier RS unit, load buffers and similar.
- Sits directly downstream of each unit's CDB_rts output and drives each unit's CDB_xmit tri-state enable.
- Grants one requester at a time with round-robin fairness.
- Registers the broadcast (source tag and data) into a clean one-cycle pulse for the register status table and reorder logic.

Parameters:
- NUM_UNITS, 4, number of functional units requesting the CDB (2..8).
- XMIT_CYCLES, 1, clock cycles CDB_xmit stays high per grant (1..15).
- TAG_W, 6, width of CDB_source tags.
- DATA_W, 32, width of CDB_data.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rts  in  NUM_UNITS  per-unit ready-to-send (each unit's CDB_rts).
- xmit  out  NUM_UNITS  one-hot grant; drives each unit's CDB_xmit.
- CDB_data  in  DATA_W  shared bus, sampled only.
- CDB_source  in  TAG_W  shared bus, sampled only.
- CDB_write  in  1  shared bus write-valid, sampled only.
- cdb_busy  out  1  high while any xmit bit is high.
- grant_id  out  clog2(NUM_UNITS)  index of the current/last granted unit.
- bc_valid  out  1  one-cycle broadcast pulse.
- bc_tag  out  TAG_W  tag latched from CDB_source.
- bc_data  out  DATA_W  data latched from CDB_data.
- protocol_error  out  1  one-cycle pulse; active only with the optional feature.

Behaviour:
- Reset values: xmit=0, cdb_busy=0, grant_id=0, bc_valid=0, bc_tag=0, bc_data=0, protocol_error=0, rr_ptr=0, FSM=IDLE, hold counter=0.
- All outputs are registered.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any rts bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_UNITS.
  - Set xmit to that one-hot value, grant_id=winner, counter=XMIT_CYCLES-1, go to GRANT.
  - Latency: rts sampled high at edge N gives xmit high after edge N.
  - No requests: stay in IDLE with xmit=0.
- GRANT:
  - Hold xmit; decrement counter each cycle.
  - When counter==0: sample CDB_source/CDB_data into bc_tag/bc_data and pulse bc_valid for the next cycle.
  - In the same cycle: clear xmit, set rr_ptr=(winner+1) mod NUM_UNITS, go to RELEASE.
- RELEASE:
  - Exactly one cycle with xmit=0.
  - Units clear rts on the falling edge of xmit; this cycle guarantees the winner's stale rts is low before the next arbitration.
  - Then go to IDLE.
- Back-to-back grants therefore run at one grant per XMIT_CYCLES+2 cycles.
- rts behaviour:
  - A unit raising rts during GRANT or RELEASE waits; rts is level-sensitive and is not latched.
  - Winner dropping rts mid-GRANT: grant still completes; broadcast still occurs.
- Simultaneous requests: round-robin order only; every unit is served within NUM_UNITS grants.
- rr_ptr wraps from NUM_UNITS-1 to 0.
- xmit is never more than one-hot; cdb_busy = |xmit.
- Reset mid-GRANT: xmit drops on that edge, no bc_valid. The unit sees a falling xmit and discards its result; this is accepted behaviour, since reset flushes the machine.
- grant_id holds its last value outside GRANT.

Optional Feature:
- Macro CDB_ARB_WRITE_CHECK_EN.
- Defined: at the final GRANT cycle, if CDB_write!=1 or CDB_source==0, suppress bc_valid and pulse protocol_error for one cycle instead. rr_ptr still advances.
- Undefined: bc_valid fires unconditionally at the end of every grant; protocol_error is tied to 0.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10).
  - no_rs tag constant 6'b000000.
  - Default TAG_W/DATA_W.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the request vector and a start pointer; outputs are the winner index and a found flag.
- The FSM, counter and broadcast registers stay in cdb_arbiter.

Test Plan:
- Single request: rts=4'b0010 from reset, CDB_source=6'd2, CDB_data=32'd7 → xmit=4'b0010 for 1 cycle; one cycle later bc_valid=1, bc_tag=2, bc_data=7; rr_ptr=2.
- Contention: rts=4'b1011 held (requester drops rts on xmit fall, re-raises next cycle) → grant order units 0,1,3,0,1,3; no overlapping xmit bits.
- Hold length: XMIT_CYCLES=3 → xmit high exactly 3 cycles, RELEASE 1 cycle, next grant 5 cycles after previous start.
- Wrap-around: rr_ptr=3 with rts=4'b1001 → unit 3 granted, then unit 0, rr_ptr wraps to 0 then 1.
- Reset mid-GRANT (XMIT_CYCLES=4, reset at cycle 2) → xmit=0 next cycle, bc_valid stays 0, rr_ptr=0.
- With CDB_ARB_WRITE_CHECK_EN: granted unit holds CDB_write=0 → protocol_error pulses 1 cycle, bc_valid stays 0. Without the macro → bc_valid=1.
